// File: rtl/aftab_mem_arbiter_pkg.sv
// Shared encodings for the AFTAB memory-port arbiter: FSM states and requester indices.
package aftab_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GNT_CORE = 2'b01,
    GNT_DBG  = 2'b10
  } arb_state_t;

  localparam int REQ_CORE = 0;
  localparam int REQ_DBG  = 1;
  localparam int NUM_REQ  = 2;

endpackage

// File: rtl/aftab_mem_arb_mux.sv
// Combinational memory-port mux and ready router, steered by the arbiter's registered state.
module aftab_mem_arb_mux
  import aftab_mem_arbiter_pkg::*;
#(
  parameter int size = 32
) (
  input  arb_state_t      state,
  input  logic            kill,
  input  logic [size-1:0] coreAddr,
  input  logic [7:0]      coreDataIn,
  input  logic            coreWrite,
  input  logic            coreRead,
  input  logic [size-1:0] dbgAddr,
  input  logic [7:0]      dbgDataIn,
  input  logic            dbgWrite,
  input  logic            dbgRead,
  input  logic            memReady,
  output logic [size-1:0] memAddr,
  output logic [7:0]      memDataOut,
  output logic            writeMem,
  output logic            readMem,
  output logic            coreReady,
  output logic            dbgReady
);

  logic wr_sel;
  logic rd_sel;

  always_comb begin
    memAddr    = '0;
    memDataOut = '0;
    wr_sel     = 1'b0;
    rd_sel     = 1'b0;
    case (state)
      GNT_CORE: begin
        memAddr    = coreAddr;
        memDataOut = coreDataIn;
        wr_sel     = coreWrite;
        rd_sel     = coreRead;
      end
      GNT_DBG: begin
        memAddr    = dbgAddr;
        memDataOut = dbgDataIn;
        wr_sel     = dbgWrite;
        rd_sel     = dbgRead;
      end
      default: ;
    endcase
  end

  // A requester asserting both strobes gets a write; a timeout kills both.
  assign writeMem  = wr_sel & ~kill;
  assign readMem   = rd_sel & ~wr_sel & ~kill;

  assign coreReady = memReady & (state == GNT_CORE);
  assign dbgReady  = memReady & (state == GNT_DBG);

endmodule

// File: rtl/aftab_mem_arbiter.sv
// Whole-transaction arbiter between the core byte engines and debug system-bus access.
// Optional memReady timeout with busError is enabled by defining AFTAB_MEM_ARB_TIMEOUT_EN.
module aftab_mem_arbiter
  import aftab_mem_arbiter_pkg::*;
#(
  parameter int size          = 32,
  parameter int DBG_BURST_MAX = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            coreReq,
  input  logic [size-1:0] coreAddr,
  input  logic [7:0]      coreDataIn,
  input  logic            coreWrite,
  input  logic            coreRead,
  output logic            coreGnt,
  output logic            coreReady,
  input  logic            dbgReq,
  input  logic [size-1:0] dbgAddr,
  input  logic [7:0]      dbgDataIn,
  input  logic            dbgWrite,
  input  logic            dbgRead,
  output logic            dbgGnt,
  output logic            dbgReady,
  output logic [size-1:0] memAddr,
  output logic [7:0]      memDataOut,
  input  logic [7:0]      memDataIn,
  output logic            writeMem,
  output logic            readMem,
  input  logic            memReady,
  output logic            busError
);

  localparam int BW = $clog2(DBG_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(DBG_BURST_MAX);

  arb_state_t          state_reg, state_next;
  logic [BW-1:0]       burst_cnt_reg, burst_cnt_next;
  logic [NUM_REQ-1:0]  req_vec, blocked, eligible;
  logic                timeout_hit;
  logic                unused_mem_data;

  // Requesters take read data straight off the memory bus; nothing here consumes it.
  assign unused_mem_data = ^memDataIn;

  assign req_vec[REQ_CORE] = coreReq;
  assign req_vec[REQ_DBG]  = dbgReq;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign eligible[gi] = req_vec[gi] & ~blocked[gi];
  end

`ifdef AFTAB_MEM_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0]      to_cnt_reg;
  logic [NUM_REQ-1:0] blocked_reg, own_vec, strobe_vec;
  logic               owner_strobe;

  assign own_vec[REQ_CORE]    = (state_reg == GNT_CORE);
  assign own_vec[REQ_DBG]     = (state_reg == GNT_DBG);
  assign strobe_vec[REQ_CORE] = coreWrite | coreRead;
  assign strobe_vec[REQ_DBG]  = dbgWrite | dbgRead;
  assign owner_strobe         = |(own_vec & strobe_vec);
  assign timeout_hit          = (to_cnt_reg == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_reg <= '0;
    end else if (state_reg == IDLE || timeout_hit || memReady || !owner_strobe) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end

  // A timed-out owner must show one low cycle on req before it can be granted again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blocked_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_vec[i])
          blocked_reg[i] <= 1'b0;
        else if (timeout_hit && own_vec[i])
          blocked_reg[i] <= 1'b1;
      end
    end
  end

  assign blocked  = blocked_reg;
  assign busError = timeout_hit;
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout_hit = 1'b0;
  assign blocked     = '0;
  assign busError    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (eligible[REQ_DBG] && (!eligible[REQ_CORE] || burst_cnt_reg < BURST_MAX))
          state_next = GNT_DBG;
        else if (eligible[REQ_CORE])
          state_next = GNT_CORE;
      end
      GNT_CORE: if (!coreReq || timeout_hit) state_next = IDLE;
      GNT_DBG:  if (!dbgReq || timeout_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // The burst count only tracks debug grants that made the core wait.
    if (state_reg == IDLE && state_next == GNT_DBG) begin
      if (!coreReq)
        burst_cnt_next = '0;
      else if (burst_cnt_reg < BURST_MAX)
        burst_cnt_next = burst_cnt_reg + BW'(1);
    end else if (state_reg == IDLE && state_next == GNT_CORE) begin
      burst_cnt_next = '0;
    end
  end

  assign coreGnt = (state_reg == GNT_CORE);
  assign dbgGnt  = (state_reg == GNT_DBG);

  aftab_mem_arb_mux #(
    .size(size)
  ) u_mux (
    .state      (state_reg),
    .kill       (timeout_hit),
    .coreAddr   (coreAddr),
    .coreDataIn (coreDataIn),
    .coreWrite  (coreWrite),
    .coreRead   (coreRead),
    .dbgAddr    (dbgAddr),
    .dbgDataIn  (dbgDataIn),
    .dbgWrite   (dbgWrite),
    .dbgRead    (dbgRead),
    .memReady   (memReady),
    .memAddr    (memAddr),
    .memDataOut (memDataOut),
    .writeMem   (writeMem),
    .readMem    (readMem),
    .coreReady  (coreReady),
    .dbgReady   (dbgReady)
  );

endmodule

// File: tb/tb_aftab_mem_arbiter.sv
// Scoreboard bench for aftab_mem_arbiter: strobe transactions and grant order are queued
// when driven and compared when they appear on the memory port.
module tb_aftab_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        coreReq, coreWrite, coreRead, coreGnt, coreReady;
  logic [31:0] coreAddr;
  logic [7:0]  coreDataIn;
  logic        dbgReq, dbgWrite, dbgRead, dbgGnt, dbgReady;
  logic [31:0] dbgAddr;
  logic [7:0]  dbgDataIn;
  logic [31:0] memAddr;
  logic [7:0]  memDataOut, memDataIn;
  logic        writeMem, readMem, memReady, busError;

  int checks = 0;
  int errors = 0;

  logic [43:0] txn_q[$];
  logic [1:0]  gnt_q[$];
  bit          arb_en = 1'b0;

  always #5 clk = ~clk;

  aftab_mem_arbiter #(
    .size(32),
    .DBG_BURST_MAX(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .coreReq(coreReq), .coreAddr(coreAddr), .coreDataIn(coreDataIn),
    .coreWrite(coreWrite), .coreRead(coreRead), .coreGnt(coreGnt), .coreReady(coreReady),
    .dbgReq(dbgReq), .dbgAddr(dbgAddr), .dbgDataIn(dbgDataIn),
    .dbgWrite(dbgWrite), .dbgRead(dbgRead), .dbgGnt(dbgGnt), .dbgReady(dbgReady),
    .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn),
    .writeMem(writeMem), .readMem(readMem), .memReady(memReady), .busError(busError)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h (t=%0t)", tag, got, $time);
    end
  endtask

  function automatic logic [43:0] pack(input logic [1:0] who, input logic wr, input logic rd,
                                       input logic [31:0] a, input logic [7:0] d);
    return {who, wr, rd, a, d};
  endfunction

  // Monitor: grant rises and strobe rises are popped against the queues.
  logic prev_core = 1'b0, prev_dbg = 1'b0, prev_strobe = 1'b0;
  always @(negedge clk) begin
    logic [43:0] obs;
    logic [43:0] exp_t;
    logic [1:0]  exp_g;
    if ((coreGnt && !prev_core) || (dbgGnt && !prev_dbg)) begin
      check("gnt_idle_gap", {62'd0, prev_core, prev_dbg}, 64'd0);
      if (arb_en && gnt_q.size() > 0) begin
        exp_g = gnt_q.pop_front();
        check("gnt_order", {62'd0, dbgGnt, coreGnt}, {62'd0, exp_g});
      end
    end
    if ((writeMem || readMem) && !prev_strobe) begin
      obs = pack({dbgGnt, coreGnt}, writeMem, readMem, memAddr, memDataOut);
      if (txn_q.size() == 0) begin
        check("txn_unexpected", {20'd0, obs}, 64'd0);
      end else begin
        exp_t = txn_q.pop_front();
        check("txn", {20'd0, obs}, {20'd0, exp_t});
      end
    end
    prev_core   <= coreGnt;
    prev_dbg    <= dbgGnt;
    prev_strobe <= writeMem | readMem;
  end

  task automatic xfer(input bit dbg, input logic [31:0] base, input logic [7:0] dbase,
                      input int n, input bit wr, input bit rd, input bit chk_lat);
    int w;
    @(posedge clk); #1;
    if (dbg) dbgReq = 1'b1; else coreReq = 1'b1;
    @(negedge clk);
    if (chk_lat) check("gnt_lat_cycle0", {63'd0, dbg ? dbgGnt : coreGnt}, 64'd0);
    w = 0;
    while (!(dbg ? dbgGnt : coreGnt) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("gnt_wait", {63'd0, dbg ? dbgGnt : coreGnt}, 64'd1);
    if (chk_lat) check("gnt_lat_cycles", w, 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (dbg) begin
        dbgAddr = base + i; dbgDataIn = dbase + 8'(i); dbgWrite = wr; dbgRead = rd;
      end else begin
        coreAddr = base + i; coreDataIn = dbase + 8'(i); coreWrite = wr; coreRead = rd;
      end
      txn_q.push_back(pack(dbg ? 2'b10 : 2'b01, wr, rd & ~wr, base + i, dbase + 8'(i)));
      @(posedge clk); #1;
      if (dbg) begin dbgWrite = 1'b0; dbgRead = 1'b0; end
      else begin coreWrite = 1'b0; coreRead = 1'b0; end
      memReady  = 1'b1;
      memDataIn = 8'h40 + 8'(i);
      if (i == n - 1) begin
        if (dbg) dbgReq = 1'b0; else coreReq = 1'b0;
      end
      @(negedge clk);
      check("ready_route", {62'd0, coreReady, dbgReady}, dbg ? 64'd1 : 64'd2);
      check("buserr_quiet", {63'd0, busError}, 64'd0);
      @(posedge clk); #1;
      memReady = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic exp_err, exp_gnt;
    // Reset with busy-looking inputs: every output must read zero.
    rst = 1'b0;
    coreReq = 1'b1; coreAddr = 32'h1234; coreDataIn = 8'hAA; coreWrite = 1'b1; coreRead = 1'b0;
    dbgReq = 1'b1; dbgAddr = 32'h5678; dbgDataIn = 8'hBB; dbgWrite = 1'b0; dbgRead = 1'b1;
    memReady = 1'b1; memDataIn = 8'h00;
    #12;
    check("rst_gnt", {62'd0, coreGnt, dbgGnt}, 64'd0);
    check("rst_ready", {62'd0, coreReady, dbgReady}, 64'd0);
    check("rst_addr", {32'd0, memAddr}, 64'd0);
    check("rst_wdata", {56'd0, memDataOut}, 64'd0);
    check("rst_strobe", {62'd0, writeMem, readMem}, 64'd0);
    check("rst_buserr", {63'd0, busError}, 64'd0);
    coreReq = 0; coreWrite = 0; dbgReq = 0; dbgRead = 0; memReady = 0;
    coreAddr = 0; dbgAddr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {62'd0, coreGnt, dbgGnt}, 64'd0);

    // memReady in IDLE is ignored.
    @(posedge clk); #1;
    memReady = 1'b1;
    @(negedge clk);
    check("late_ready", {62'd0, coreReady, dbgReady}, 64'd0);
    @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk);
    check("late_ready_state", {62'd0, coreGnt, dbgGnt}, 64'd0);

    // Single 4-byte core store.
    xfer(1'b0, 32'h100, 8'hA0, 4, 1'b1, 1'b0, 1'b1);

    // Debug strobes while core owns the port must not leak through.
    dbgAddr = 32'hDEAD_BEEF; dbgDataIn = 8'h77; dbgWrite = 1'b1;
    xfer(1'b0, 32'h200, 8'h10, 2, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 32'h210, 8'h33, 1, 1'b1, 1'b1, 1'b0);
    dbgWrite = 1'b0; dbgAddr = 32'h0;

    // Both requesting continuously: four debug grants then one core grant.
    gnt_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    arb_en = 1'b1;
    @(posedge clk); #1;
    coreReq = 1'b1; dbgReq = 1'b1;
    cyc = 0;
    while (gnt_q.size() > 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (coreGnt) coreReq = 1'b0; else if (!coreReq) coreReq = 1'b1;
      if (dbgGnt) dbgReq = 1'b0; else if (!dbgReq) dbgReq = 1'b1;
    end
    coreReq = 1'b0; dbgReq = 1'b0;
    arb_en = 1'b0;
    check("arb_grants_left", gnt_q.size(), 64'd0);
    @(posedge clk); @(posedge clk);

    // Debug store.
    xfer(1'b1, 32'h300, 8'hC0, 2, 1'b1, 1'b0, 1'b1);

    // Core read whose memReady never arrives.
    @(posedge clk); #1;
    coreReq = 1'b1;
    @(negedge clk); @(negedge clk);
    check("to_gnt", {63'd0, coreGnt}, 64'd1);
    @(posedge clk); #1;
    coreAddr = 32'h400; coreDataIn = 8'h00; coreRead = 1'b1;
    txn_q.push_back(pack(2'b01, 1'b0, 1'b1, 32'h400, 8'h00));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
`ifdef AFTAB_MEM_ARB_TIMEOUT_EN
      exp_err = (k == 8);
      exp_gnt = (k <= 8);
`else
      exp_err = 1'b0;
      exp_gnt = 1'b1;
`endif
      check($sformatf("to_buserr_%0d", k), {63'd0, busError}, {63'd0, exp_err});
      check($sformatf("to_gnt_%0d", k), {63'd0, coreGnt}, {63'd0, exp_gnt});
    end
    @(posedge clk); #1;
    coreRead = 1'b0; coreReq = 1'b0;
    @(posedge clk); #1;
    coreReq = 1'b1;
    @(negedge clk);
    check("regrant_cycle0", {63'd0, coreGnt}, 64'd0);
    @(negedge clk);
    check("regrant", {63'd0, coreGnt}, 64'd1);
    @(posedge clk); #1;
    coreReq = 1'b0;
    @(posedge clk); @(posedge clk);

    // Asynchronous reset in the middle of a core write.
    @(posedge clk); #1;
    coreReq = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rmid_gnt", {63'd0, coreGnt}, 64'd1);
    @(posedge clk); #1;
    coreWrite = 1'b1; coreAddr = 32'h500; coreDataIn = 8'h5A;
    #1;
    check("rmid_pre_write", {63'd0, writeMem}, 64'd1);
    check("rmid_pre_addr", {32'd0, memAddr}, 64'h500);
    memReady = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("rmid_gnt_async", {62'd0, coreGnt, dbgGnt}, 64'd0);
    check("rmid_strobe_async", {62'd0, writeMem, readMem}, 64'd0);
    check("rmid_addr_async", {32'd0, memAddr}, 64'd0);
    check("rmid_wdata_async", {56'd0, memDataOut}, 64'd0);
    check("rmid_ready_async", {62'd0, coreReady, dbgReady}, 64'd0);
    coreReq = 1'b0; coreWrite = 1'b0; memReady = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rmid_idle", {62'd0, coreGnt, dbgGnt}, 64'd0);

    @(negedge clk);
    check("txn_q_empty", txn_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
